// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI4-Lite master engine.
package axil_pkg;

  localparam int AXIL_ADDR_W = 32;
  localparam int AXIL_DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_RESP,
    ST_DONE
  } axil_state_e;

  typedef struct packed {
    logic                       we;
    logic [AXIL_ADDR_W-1:0]     addr;
    logic [AXIL_DATA_W-1:0]     wdata;
    logic [AXIL_DATA_W/8-1:0]   wstrb;
  } axil_cmd_t;

endpackage

// File: rtl/axil_master_engine_if.sv
// Command/response port and AXI4-Lite bus of the master engine.
interface axil_master_engine_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_we;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_wdata;
  logic [DATA_W/8-1:0] cmd_wstrb;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [DATA_W-1:0]   rsp_rdata;
  logic [1:0]          rsp_resp;
  logic                rsp_timeout;

  logic                m_axi_awvalid, m_axi_awready;
  logic [ADDR_W-1:0]   m_axi_awaddr;
  logic [2:0]          m_axi_awprot;
  logic                m_axi_wvalid, m_axi_wready;
  logic [DATA_W-1:0]   m_axi_wdata;
  logic [DATA_W/8-1:0] m_axi_wstrb;
  logic                m_axi_bvalid, m_axi_bready;
  logic [1:0]          m_axi_bresp;
  logic                m_axi_arvalid, m_axi_arready;
  logic [ADDR_W-1:0]   m_axi_araddr;
  logic [2:0]          m_axi_arprot;
  logic                m_axi_rvalid, m_axi_rready;
  logic [DATA_W-1:0]   m_axi_rdata;
  logic [1:0]          m_axi_rresp;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    input  m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_bresp,
    input  m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rresp,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
    output m_axi_awvalid, m_axi_awaddr, m_axi_awprot, m_axi_wvalid, m_axi_wdata, m_axi_wstrb,
    output m_axi_bready, m_axi_arvalid, m_axi_araddr, m_axi_arprot, m_axi_rready
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    output m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_bresp,
    output m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rresp,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
    input  m_axi_awvalid, m_axi_awaddr, m_axi_awprot, m_axi_wvalid, m_axi_wdata, m_axi_wstrb,
    input  m_axi_bready, m_axi_arvalid, m_axi_araddr, m_axi_arprot, m_axi_rready
  );
endinterface

// File: rtl/axil_timeout_cnt.sv
// Bounded-wait timer: counts enabled cycles since the last clear and flags the
// last allowed cycle. CYCLES = 0 disables expiry.
module axil_timeout_cnt #(
  parameter int unsigned CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);
  localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = (CYCLES == 0) ? '0 : CW'(CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // Saturates at LAST so a missed expiry can never wrap around
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_expire = (CYCLES != 0) && i_en && (r_cnt == LAST);
endmodule

// File: rtl/axil_master_engine.sv
// AXI4-Lite master: one single-beat read or write per accepted command, with
// concurrent AW/W issue and a bounded-wait abort.
module axil_master_engine
  import axil_pkg::*;
#(
  parameter int unsigned ADDR_W         = AXIL_ADDR_W,
  parameter int unsigned DATA_W         = AXIL_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [2:0]  AWPROT_VAL     = 3'b000
) (
  input logic                  aclk,
  input logic                  areset,
  axil_master_engine_if.master axil
);
  axil_state_e         r_state, w_state_nxt;
  logic                r_awvalid, w_awvalid_nxt;
  logic                r_wvalid, w_wvalid_nxt;
  logic                r_arvalid, w_arvalid_nxt;
  logic                r_bready, w_bready_nxt;
  logic                r_rready, w_rready_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
  logic [DATA_W/8-1:0] r_wstrb, w_wstrb_nxt;
  logic [DATA_W-1:0]   r_rsp_rdata, w_rsp_rdata_nxt;
  logic [1:0]          r_rsp_resp, w_rsp_resp_nxt;
  logic                r_rsp_timeout, w_rsp_timeout_nxt;
  logic                w_clr, w_en, w_expire, w_final_hs;

  assign w_en = (r_state != ST_IDLE) && (r_state != ST_DONE);

  axil_timeout_cnt #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk      (aclk),
    .rst      (areset),
    .i_clr    (w_clr),
    .i_en     (w_en),
    .o_expire (w_expire)
  );

  assign w_final_hs = ((r_state == ST_WR_RESP) && axil.m_axi_bvalid) ||
                      ((r_state == ST_RD_RESP) && axil.m_axi_rvalid);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state       <= ST_IDLE;
      r_awvalid     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_arvalid     <= 1'b0;
      r_bready      <= 1'b0;
      r_rready      <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
      r_rsp_rdata   <= '0;
      r_rsp_resp    <= RESP_OKAY;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_awvalid     <= w_awvalid_nxt;
      r_wvalid      <= w_wvalid_nxt;
      r_arvalid     <= w_arvalid_nxt;
      r_bready      <= w_bready_nxt;
      r_rready      <= w_rready_nxt;
      r_addr        <= w_addr_nxt;
      r_wdata       <= w_wdata_nxt;
      r_wstrb       <= w_wstrb_nxt;
      r_rsp_rdata   <= w_rsp_rdata_nxt;
      r_rsp_resp    <= w_rsp_resp_nxt;
      r_rsp_timeout <= w_rsp_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_awvalid_nxt     = r_awvalid;
    w_wvalid_nxt      = r_wvalid;
    w_arvalid_nxt     = r_arvalid;
    w_bready_nxt      = r_bready;
    w_rready_nxt      = r_rready;
    w_addr_nxt        = r_addr;
    w_wdata_nxt       = r_wdata;
    w_wstrb_nxt       = r_wstrb;
    w_rsp_rdata_nxt   = r_rsp_rdata;
    w_rsp_resp_nxt    = r_rsp_resp;
    w_rsp_timeout_nxt = r_rsp_timeout;
    w_clr             = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (axil.cmd_valid) begin
          w_clr             = 1'b1;
          w_addr_nxt        = axil.cmd_addr;
          w_wdata_nxt       = axil.cmd_wdata;
          w_wstrb_nxt       = axil.cmd_wstrb;
          w_rsp_rdata_nxt   = '0;
          w_rsp_resp_nxt    = RESP_OKAY;
          w_rsp_timeout_nxt = 1'b0;
          if (axil.cmd_we) begin
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
            w_state_nxt   = ST_WR_REQ;
          end else begin
            w_arvalid_nxt = 1'b1;
            w_state_nxt   = ST_RD_REQ;
          end
        end
      end
      ST_WR_REQ: begin
        w_awvalid_nxt = r_awvalid && !axil.m_axi_awready;
        w_wvalid_nxt  = r_wvalid && !axil.m_axi_wready;
        if (!w_awvalid_nxt && !w_wvalid_nxt) begin
          w_bready_nxt = 1'b1;
          w_state_nxt  = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        if (axil.m_axi_bvalid) begin
          w_rsp_resp_nxt  = axil.m_axi_bresp;
          w_rsp_rdata_nxt = '0;
          w_bready_nxt    = 1'b0;
          w_state_nxt     = ST_DONE;
        end
      end
      ST_RD_REQ: begin
        if (axil.m_axi_arready) begin
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
          w_state_nxt   = ST_RD_RESP;
        end
      end
      ST_RD_RESP: begin
        if (axil.m_axi_rvalid) begin
          w_rsp_rdata_nxt = axil.m_axi_rdata;
          w_rsp_resp_nxt  = axil.m_axi_rresp;
          w_rready_nxt    = 1'b0;
          w_state_nxt     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (axil.rsp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Abort beats any intermediate handshake but loses to the final B/R one
    if (w_expire && !w_final_hs) begin
      w_awvalid_nxt     = 1'b0;
      w_wvalid_nxt      = 1'b0;
      w_arvalid_nxt     = 1'b0;
      w_bready_nxt      = 1'b0;
      w_rready_nxt      = 1'b0;
      w_rsp_timeout_nxt = 1'b1;
      w_rsp_resp_nxt    = RESP_SLVERR;
      w_state_nxt       = ST_DONE;
    end
  end

  assign axil.cmd_ready     = (r_state == ST_IDLE) && !areset;
  assign axil.rsp_valid     = (r_state == ST_DONE);
  assign axil.rsp_rdata     = r_rsp_rdata;
  assign axil.rsp_resp      = r_rsp_resp;
  assign axil.rsp_timeout   = r_rsp_timeout;
  assign axil.m_axi_awvalid = r_awvalid;
  assign axil.m_axi_awaddr  = r_addr;
  assign axil.m_axi_awprot  = AWPROT_VAL;
  assign axil.m_axi_wvalid  = r_wvalid;
  assign axil.m_axi_wdata   = r_wdata;
  assign axil.m_axi_wstrb   = r_wstrb;
  assign axil.m_axi_bready  = r_bready;
  assign axil.m_axi_arvalid = r_arvalid;
  assign axil.m_axi_araddr  = r_addr;
  assign axil.m_axi_arprot  = AWPROT_VAL;
  assign axil.m_axi_rready  = r_rready;
endmodule

// File: doc/axil_master_engine.md
Name: axil_master_engine

Overview:
- Synthesizable AXI4-Lite master that executes one single-beat read or write per command, taken from a simple valid/ready command port.
- Returns read data, BRESP/RRESP and a timeout flag on a valid/ready response port.
- Parametrised successor of the bench-side write/read tasks: configurable address/data width, concurrent AW/W issue with independent handshake completion, and a bounded-wait timeout.
- Sits between a register-sequencing controller (or bench driver) and any AXI4-Lite slave.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 32, AXI data width; legal values 32 or 64; strobe width is DATA_W/8.
- TIMEOUT_CYCLES, 256, maximum cycles from command accept to B/R handshake; 0 disables the timeout.
- AWPROT_VAL, 3'b000, constant driven on m_axi_awprot and m_axi_arprot.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine can accept a command.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data.
- cmd_wstrb  in  DATA_W/8  write strobes.
- rsp_valid  out  1  result present.
- rsp_ready  in  1  result consumed.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_resp  out  2  captured BRESP/RRESP; 2'b10 on timeout.
- rsp_timeout  out  1  transaction aborted by timeout.
- m_axi_aw{valid,ready,addr,prot}, m_axi_w{valid,ready,data,strb}, m_axi_b{valid,ready,resp}, m_axi_ar{valid,ready,addr,prot}, m_axi_r{valid,ready,data,resp}: standard AXI4-Lite master directions and widths.

Behaviour:
- Reset: all *valid/*ready outputs = 0; rsp_rdata, rsp_resp, rsp_timeout = 0; address/data outputs = 0; FSM = IDLE; timeout counter = 0.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, register addr/wdata/wstrb/we and clear the timeout counter.
  - we = 1: next state WR_REQ; awvalid and wvalid both rise the next cycle.
  - we = 0: next state RD_REQ; arvalid rises the next cycle.
  - Accept-to-valid latency is 1 cycle.
- WR_REQ:
  - awvalid drops on the clock edge where awvalid & awready.
  - wvalid drops on the clock edge where wvalid & wready.
  - AW and W may complete in either order or in the same cycle.
  - Exit to WR_RESP when both have completed; bready asserts on that transition.
- WR_RESP:
  - bready held 1.
  - On bvalid, capture bresp, set rsp_rdata = 0, go to DONE, deassert bready.
- RD_REQ: arvalid drops on handshake; go to RD_RESP with rready = 1.
- RD_RESP: on rvalid, capture rdata/rresp, go to DONE, deassert rready.
- Response readiness: bready/rready are asserted only in the *_RESP states. A slave asserting bvalid/rvalid early simply waits.
- DONE:
  - rsp_valid = 1; hold rsp outputs stable until rsp_valid & rsp_ready, then go to IDLE.
  - cmd_ready = 0 in every state except IDLE, so only one outstanding transaction.
- Timeout:
  - Counter increments every cycle outside IDLE and DONE.
  - When it reaches TIMEOUT_CYCLES, force all m_axi valids/readies to 0, set rsp_timeout = 1 and rsp_resp = 2'b10, and go to DONE.
  - This is a recovery action. After a timeout the slave must be reset before further use; the engine does not drain late responses.
- Simultaneous events: if the final handshake and the timeout occur in the same cycle, the handshake wins; rsp_timeout = 0.
- AXI valid stability: AXI valid signals never drop without a handshake except on timeout or reset.
- Reset mid-operation returns to the reset state immediately, from any state.

Decomposition:
- Shared package axil_pkg holds:
  - state enum axil_state_e;
  - resp constants RESP_OKAY = 2'b00, RESP_EXOKAY = 2'b01, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11;
  - struct axil_cmd_t {we, addr, wdata, wstrb} parametrised by width localparams.
- One natural sub-module, axil_timeout_cnt: counter with clear, enable, expire output and a 0 = disabled option.

Test Plan:
- Write, slave ready immediately: cmd we=1, addr=0x10, wdata=0xDEADBEEF, wstrb=0xF; awready=wready=1, bvalid one cycle after the W handshake with bresp=0 -> awvalid/wvalid high exactly 1 cycle; rsp_valid with rsp_resp=0, rsp_timeout=0, rsp_rdata=0.
- Write, skewed handshakes: awready at cycle 1, wready at cycle 4, bvalid at cycle 6 with bresp=2 -> awvalid drops after cycle 1, wvalid stays high until cycle 4; rsp_resp=2.
- Read with backpressure: addr=0x24; arready after 3 cycles, rvalid with rdata=0x12345678, rresp=0; rsp_ready held low for 5 cycles -> rsp outputs stable through the hold; cmd_ready=0 until rsp is consumed.
- Timeout: TIMEOUT_CYCLES=8, read with arready stuck at 0 -> exactly 8 cycles after accept, arvalid=0; rsp_timeout=1, rsp_resp=2; rvalid arriving on cycle 8 itself -> handshake wins, rsp_timeout=0.
- Reset mid-write: assert areset while awvalid=1 and wvalid=1 -> all outputs 0 asynchronously; after release, cmd_ready=1 and a following read to 0x0 completes normally.
- DATA_W=64: write with wstrb=0xF0 and wdata=0xAABBCCDD_00000000 -> m_axi_wstrb=0xF0 and data driven unchanged.
